qmax_ctrl: RTL and testbench

- Sequencer and arbiter for the single-read/single-write qmax BRAM. The BRAM holds one signed fixed-point max-Q value per state and has 1-cycle registered read latency.
- After reset it clears the table, then shares the read port between two requesters:
  - the update path, which does read-compare-write-if-greater;
  - the query path, which returns qmax[s'] for the Q-update datapath.
- Forwarding hides the BRAM's write/read collision so back-to-back same-address operations see the newest value.

---
 rtl/qmax_ctrl_if.sv | 35 +++
 rtl/qmax_ctrl.sv | 123 ++++++++++++
 tb/tb_qmax_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/qmax_ctrl_if.sv
// Request, response and BRAM-port signals of the qmax table controller.
// The slave modport is the controller; the master modport is its environment.
interface qmax_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) ();
    logic                  i_upd_valid;
    logic                  o_upd_ready;
    logic [ADDR_WIDTH-1:0] i_upd_addr;
    logic [DATA_WIDTH-1:0] i_upd_data;
    logic                  i_qry_valid;
    logic                  o_qry_ready;
    logic [ADDR_WIDTH-1:0] i_qry_addr;
    logic                  o_qry_rvalid;
    logic [DATA_WIDTH-1:0] o_qry_rdata;
    logic                  o_init_done;
    logic [ADDR_WIDTH-1:0] o_tbl_addr_r;
    logic                  o_tbl_read_en;
    logic [ADDR_WIDTH-1:0] o_tbl_addr_w;
    logic                  o_tbl_write_en;
    logic [DATA_WIDTH-1:0] o_tbl_wdata;
    logic [DATA_WIDTH-1:0] i_tbl_rdata;

    modport slave (
        input  i_upd_valid, i_upd_addr, i_upd_data, i_qry_valid, i_qry_addr, i_tbl_rdata,
        output o_upd_ready, o_qry_ready, o_qry_rvalid, o_qry_rdata, o_init_done,
        output o_tbl_addr_r, o_tbl_read_en, o_tbl_addr_w, o_tbl_write_en, o_tbl_wdata
    );

    modport master (
        output i_upd_valid, i_upd_addr, i_upd_data, i_qry_valid, i_qry_addr, i_tbl_rdata,
        input  o_upd_ready, o_qry_ready, o_qry_rvalid, o_qry_rdata, o_init_done,
        input  o_tbl_addr_r, o_tbl_read_en, o_tbl_addr_w, o_tbl_write_en, o_tbl_wdata
    );
endinterface

// File: rtl/qmax_ctrl.sv
// qmax table controller: clears the BRAM after reset, then arbitrates the read port between
// read-compare-write-if-greater updates and max-Q queries, forwarding the newest write.
module qmax_ctrl #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    qmax_ctrl_if.slave  bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  rr_q, rr_d;            // 0: query wins the next tie
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_is_upd_q, s1_is_upd_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  run, grant_upd, grant_qry;
    logic                  s1_live, s1_write, s1_qry;
    logic [DATA_WIDTH-1:0] old_val;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rr_d        = rr_q;
        grant_upd   = 1'b0;
        grant_qry   = 1'b0;

        // Reset is folded in combinationally so nothing escapes in the cycle reset is applied.
        run = (state_q == ST_RUN) && !i_rst;

        if (state_q == ST_INIT) begin
            if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end

        if (run) begin
            if (bus.i_upd_valid && bus.i_qry_valid) begin
                grant_upd = rr_q;
                grant_qry = !rr_q;
                rr_d      = !rr_q;
            end else begin
                grant_upd = bus.i_upd_valid;
                grant_qry = bus.i_qry_valid;
            end
        end

        // A write committed on the same edge as this read is invisible to the BRAM output.
        old_val  = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : bus.i_tbl_rdata;
        s1_live  = s1_valid_q && !i_rst;
        s1_write = s1_live && s1_is_upd_q && ($signed(s1_data_q) > $signed(old_val));
        s1_qry   = s1_live && !s1_is_upd_q;

        s1_valid_d  = grant_upd || grant_qry;
        s1_is_upd_d = grant_upd;
        s1_addr_d   = grant_upd ? bus.i_upd_addr : bus.i_qry_addr;
        s1_data_d   = bus.i_upd_data;

        fwd_valid_d = s1_write;
        fwd_addr_d  = s1_write ? s1_addr_q : fwd_addr_q;
        fwd_data_d  = s1_write ? s1_data_q : fwd_data_q;
        rdata_d     = s1_qry ? old_val : rdata_q;

        bus.o_upd_ready   = grant_upd;
        bus.o_qry_ready   = grant_qry;
        bus.o_init_done   = run;
        bus.o_tbl_read_en = grant_upd || grant_qry;
        bus.o_tbl_addr_r  = s1_addr_d;
        bus.o_qry_rvalid  = s1_qry;
        bus.o_qry_rdata   = rdata_d;

        if (state_q == ST_INIT) begin
            bus.o_tbl_write_en = !i_rst;
            bus.o_tbl_addr_w   = init_cnt_q;
            bus.o_tbl_wdata    = INIT_VALUE;
        end else begin
            bus.o_tbl_write_en = s1_write;
            bus.o_tbl_addr_w   = s1_addr_q;
            bus.o_tbl_wdata    = s1_data_q;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rr_q        <= 1'b0;
            s1_valid_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rr_q        <= rr_d;
            s1_valid_q  <= s1_valid_d;
            fwd_valid_q <= fwd_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed under a reset valid bit.
    always_ff @(posedge i_clk) begin
        s1_is_upd_q <= s1_is_upd_d;
        s1_addr_q   <= s1_addr_d;
        s1_data_q   <= s1_data_d;
        fwd_addr_q  <= fwd_addr_d;
        fwd_data_q  <= fwd_data_d;
    end
endmodule

// File: tb/tb_qmax_ctrl.sv
// Directed bench for qmax_ctrl with a BRAM model, a reference max table and
// scoreboards for query responses and table writes.
module tb_qmax_ctrl;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam logic [DW-1:0] INIT = '0;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cycle_cnt = 0;
    int   init_k = 0;
    bit   started = 1'b0;
    bit   done_seen = 1'b0;
    logic [DW-1:0] last_rdata;
    logic [DW-1:0] ref_tbl [DEPTH];
    logic [DW-1:0] mem [DEPTH];
    exp_t exp_q[$];
    exp_t exp_w[$];
    int   gnt_log[$];

    qmax_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    qmax_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_VALUE(INIT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Read-first BRAM with one-cycle registered read.
    always @(posedge clk) begin
        if (bus.o_tbl_read_en) bus.i_tbl_rdata <= mem[bus.o_tbl_addr_r];
        if (bus.o_tbl_write_en) mem[bus.o_tbl_addr_w] <= bus.o_tbl_wdata;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) ref_tbl[i] = INIT;
        exp_q.delete();
        exp_w.delete();
        init_k     = 0;
        done_seen  = 1'b0;
        last_rdata = '0;
    endtask

    task automatic monitor();
        exp_t e;
        bit   acc_u, acc_q;
        if (!started) return;
        if (rst) begin
            chk("no_write_in_reset", 32'(bus.o_tbl_write_en), 32'd0);
            return;
        end
        if (!bus.o_init_done) begin
            if (init_k == 0) chk("rdata_reset", bus.o_qry_rdata, 32'd0);
            chk("init_wen", 32'(bus.o_tbl_write_en), 32'd1);
            chk("init_addr", 32'(bus.o_tbl_addr_w), 32'(init_k));
            chk("init_wdata", bus.o_tbl_wdata, INIT);
            chk("init_ready", 32'({bus.o_upd_ready, bus.o_qry_ready}), 32'd0);
            init_k++;
            return;
        end
        if (!done_seen) begin
            done_seen = 1'b1;
            chk("init_done_timing", 32'(init_k), 32'(DEPTH));
        end
        // Stage-1 outputs belong to earlier accepts, so retire them before recording new ones.
        if (bus.o_qry_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("qry_data", bus.o_qry_rdata, e.data);
                chk("qry_latency", 32'(cycle_cnt), 32'(e.cyc + 1));
            end
            last_rdata = bus.o_qry_rdata;
        end else begin
            chk("rdata_hold", bus.o_qry_rdata, last_rdata);
        end
        if (bus.o_tbl_write_en) begin
            if (exp_w.size() == 0) begin
                chk("unexpected_write", 32'(bus.o_tbl_addr_w), 32'hFFFF_FFFF);
            end else begin
                e = exp_w.pop_front();
                chk("write_addr", 32'(bus.o_tbl_addr_w), 32'(e.addr));
                chk("write_data", bus.o_tbl_wdata, e.data);
                chk("write_latency", 32'(cycle_cnt), 32'(e.cyc + 1));
            end
        end
        acc_u = bus.i_upd_valid && bus.o_upd_ready;
        acc_q = bus.i_qry_valid && bus.o_qry_ready;
        chk("single_grant", 32'(acc_u && acc_q), 32'd0);
        chk("read_en", 32'(bus.o_tbl_read_en), 32'(acc_u || acc_q));
        if (acc_u) begin
            gnt_log.push_back(1);
            chk("read_addr_upd", 32'(bus.o_tbl_addr_r), 32'(bus.i_upd_addr));
            if ($signed(bus.i_upd_data) > $signed(ref_tbl[bus.i_upd_addr])) begin
                ref_tbl[bus.i_upd_addr] = bus.i_upd_data;
                exp_w.push_back('{data: bus.i_upd_data, addr: bus.i_upd_addr, cyc: cycle_cnt});
            end
        end
        if (acc_q) begin
            gnt_log.push_back(0);
            chk("read_addr_qry", 32'(bus.o_tbl_addr_r), 32'(bus.i_qry_addr));
            exp_q.push_back('{data: ref_tbl[bus.i_qry_addr], addr: bus.i_qry_addr, cyc: cycle_cnt});
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cycle_cnt++;
    endtask

    task automatic set_upd(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_upd_valid = v;
        bus.i_upd_addr  = a;
        bus.i_upd_data  = d;
    endtask

    task automatic set_qry(input bit v, input logic [AW-1:0] a);
        bus.i_qry_valid = v;
        bus.i_qry_addr  = a;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 200 && !done_seen; i++) cyc();
        if (!done_seen) chk("init_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        set_upd(1'b0, '0, '0);
        set_qry(1'b0, '0);
        cyc();
        started = 1'b1;
        cyc();
        reset_model();
        rst = 1'b0;
        // Query held during init: readies must stay low until RUN.
        set_qry(1'b1, 6'd0);
        wait_init();
        set_qry(1'b0, '0);
        cyc();

        // Basic update then query.
        set_upd(1'b1, 6'd5, 32'h0001_0000); cyc();
        set_upd(1'b0, '0, '0); cyc(); cyc();
        set_qry(1'b1, 6'd5); cyc();
        set_qry(1'b0, '0); cyc();

        // Back-to-back same-address updates; the second must see the forwarded value.
        set_upd(1'b1, 6'd7, 32'h0000_0100); cyc();
        set_upd(1'b1, 6'd7, 32'h0000_0080); cyc();
        set_upd(1'b0, '0, '0);
        set_qry(1'b1, 6'd7); cyc();
        set_qry(1'b0, '0); cyc();

        // Update followed immediately by query, then a negative candidate.
        set_upd(1'b1, 6'd3, 32'h0000_0200); cyc();
        set_upd(1'b0, '0, '0);
        set_qry(1'b1, 6'd3); cyc();
        set_qry(1'b0, '0);
        set_upd(1'b1, 6'd3, 32'hFFFF_FF00); cyc();
        set_upd(1'b0, '0, '0); cyc(); cyc();

        // Signed extremes.
        set_upd(1'b1, 6'd10, 32'h8000_0000); cyc();
        set_upd(1'b1, 6'd10, 32'h7FFF_FFFF); cyc();
        set_upd(1'b0, '0, '0);
        set_qry(1'b1, 6'd10); cyc();
        set_qry(1'b0, '0);
        set_upd(1'b1, 6'd10, 32'h8000_0000); cyc();
        set_upd(1'b0, '0, '0);
        set_qry(1'b1, 6'd10); cyc();
        set_qry(1'b0, '0); cyc();

        // Contention: both valid for six cycles, pointer still at its reset value.
        gnt_log.delete();
        for (int i = 0; i < 6; i++) begin
            set_upd(1'b1, AW'(20 + i / 2), DW'((i + 1) * 16));
            set_qry(1'b1, 6'd20);
            cyc();
        end
        set_upd(1'b0, '0, '0);
        set_qry(1'b0, '0);
        cyc(); cyc();
        chk("grant_count", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) chk("grant_order", 32'(gnt_log[i]), 32'(i % 2));

        // Reset one cycle after an update is accepted: its write must never appear.
        set_upd(1'b1, 6'd9, 32'h0000_0300); cyc();
        set_upd(1'b0, '0, '0);
        rst = 1'b1; cyc();
        reset_model();
        rst = 1'b0;
        wait_init();
        set_qry(1'b1, 6'd9); cyc();
        set_qry(1'b0, '0); cyc(); cyc();

        chk("pending_queries", 32'(exp_q.size()), 32'd0);
        chk("pending_writes", 32'(exp_w.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
